// File: rtl/ahb_ram_bridge.sv
// One-outstanding-request bridge from the CPU bus interface to a single-port synchronous RAM.
// Optional macro RAND_DELAY_EN replaces the fixed DELAY with a pseudo-random delay taken from an LFSR.
module ahb_ram_bridge #(
   parameter int ADDR_W = 16,
   parameter int DELAY  = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req,
   input  logic [31:0]       addr,
   input  logic [31:0]       din,
   input  logic              wr,
   input  logic [3:0]        ben,
   output logic              addr_ok,
   output logic              data_ok,
   output logic [31:0]       dout,
   output logic              ram_en,
   output logic [3:0]        ram_wen,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [31:0]       ram_wdata,
   input  logic [31:0]       ram_rdata
);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_RESP} state_t;

   state_t            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       din_q, din_d;
   logic              wr_q, wr_d;
   logic [3:0]        ben_q, ben_d;
   logic [3:0]        dly;

   // Byte-offset and above-RAM address bits are deliberately ignored (addresses alias).
   logic unused_addr_bits;
   assign unused_addr_bits = ^{addr[31:ADDR_W+2], addr[1:0]};

`ifdef RAND_DELAY_EN
   logic [7:0] lfsr_q, lfsr_d;

   always_comb begin
      lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
   end

   always_ff @(posedge clk) begin
      if (rst) lfsr_q <= 8'h01;
      else     lfsr_q <= lfsr_d;
   end

   assign dly = lfsr_q[3:0];
`else
   assign dly = 4'(DELAY);
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      din_d   = din_q;
      wr_d    = wr_q;
      ben_d   = ben_q;
      case (state_q)
         S_IDLE: begin
            if (req) begin
               addr_d = addr[ADDR_W+1:2];
               din_d  = din;
               wr_d   = wr;
               ben_d  = ben;
               if (dly != 4'd0) begin
                  state_d = S_WAIT;
                  cnt_d   = dly - 4'd1;
               end else begin
                  state_d = S_ACCESS;
               end
            end
         end
         S_WAIT: begin
            // Dropping req while still waiting is an upstream flush: abandon silently.
            if (!req)                state_d = S_IDLE;
            else if (cnt_q == 4'd0)  state_d = S_ACCESS;
            else                     cnt_d   = cnt_q - 4'd1;
         end
         S_ACCESS: state_d = S_RESP;
         S_RESP:   state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= 4'd0;
         addr_q  <= '0;
         din_q   <= '0;
         wr_q    <= 1'b0;
         ben_q   <= 4'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         din_q   <= din_d;
         wr_q    <= wr_d;
         ben_q   <= ben_d;
      end
   end

   // Reset forces every output low so a write caught in ACCESS never reaches the RAM.
   always_comb begin
      addr_ok   = 1'b0;
      data_ok   = 1'b0;
      dout      = '0;
      ram_en    = 1'b0;
      ram_wen   = 4'd0;
      ram_addr  = '0;
      ram_wdata = '0;
      if (!rst) begin
         ram_addr  = addr_q;
         ram_wdata = din_q;
         case (state_q)
            S_IDLE:   addr_ok = 1'b1;
            S_ACCESS: begin
               ram_en  = 1'b1;
               ram_wen = ben_q & {4{wr_q}};
            end
            S_RESP: begin
               data_ok = 1'b1;
               dout    = wr_q ? 32'd0 : ram_rdata;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_ahb_ram_bridge.sv
// Bench for ahb_ram_bridge: two instances (zero and non-zero fixed delay) each with a behavioural RAM,
// directed scenarios followed by random traffic checked against a word-array memory model.
module tb_ahb_ram_bridge;

   localparam int AW   = 8;
   localparam int DLY0 = 0;
   localparam int DLY1 = 3;
   localparam int LATE = 100;

   logic        clk;
   logic        rst;
   logic        req_s       [2];
   logic [31:0] addr_s      [2];
   logic [31:0] din_s       [2];
   logic        wr_s        [2];
   logic [3:0]  ben_s       [2];
   logic        addr_ok_s   [2];
   logic        data_ok_s   [2];
   logic [31:0] dout_s      [2];
   logic        ram_en_s    [2];
   logic [3:0]  ram_wen_s   [2];
   logic [AW-1:0] ram_addr_s [2];
   logic [31:0] ram_wdata_s [2];
   logic [31:0] ram_rdata_s [2];

   int passed = 0;
   int fails  = 0;
   int total  = 0;

   ahb_ram_bridge #(.ADDR_W(AW), .DELAY(DLY0)) u_dut0 (
      .clk(clk), .rst(rst), .req(req_s[0]), .addr(addr_s[0]), .din(din_s[0]), .wr(wr_s[0]),
      .ben(ben_s[0]), .addr_ok(addr_ok_s[0]), .data_ok(data_ok_s[0]), .dout(dout_s[0]),
      .ram_en(ram_en_s[0]), .ram_wen(ram_wen_s[0]), .ram_addr(ram_addr_s[0]),
      .ram_wdata(ram_wdata_s[0]), .ram_rdata(ram_rdata_s[0]));

   ahb_ram_bridge #(.ADDR_W(AW), .DELAY(DLY1)) u_dut1 (
      .clk(clk), .rst(rst), .req(req_s[1]), .addr(addr_s[1]), .din(din_s[1]), .wr(wr_s[1]),
      .ben(ben_s[1]), .addr_ok(addr_ok_s[1]), .data_ok(data_ok_s[1]), .dout(dout_s[1]),
      .ram_en(ram_en_s[1]), .ram_wen(ram_wen_s[1]), .ram_addr(ram_addr_s[1]),
      .ram_wdata(ram_wdata_s[1]), .ram_rdata(ram_rdata_s[1]));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: bench did not reach its summary");
      $fatal(1, "timeout");
   end

   // Content of a word never written, per instance.
   function automatic logic [31:0] fill(input int k, input int w);
      return {8'(k + 1), 8'(w), 8'(w) ^ 8'hFF, 8'h3C};
   endfunction

   // Behavioural single-port RAMs attached to the DUTs.
   bit [31:0] ram_mem [2][256];
   bit        ram_vld [2][256];

   always @(posedge clk) begin
      logic [31:0] cur;
      int          a;
      for (int k = 0; k < 2; k++) begin
         if (ram_en_s[k] === 1'b1) begin
            a   = int'(ram_addr_s[k]);
            cur = ram_vld[k][a] ? ram_mem[k][a] : fill(k, a);
            ram_rdata_s[k] <= cur;
            for (int b = 0; b < 4; b++)
               if (ram_wen_s[k][b]) cur[8*b +: 8] = ram_wdata_s[k][8*b +: 8];
            if (ram_wen_s[k] != 4'd0) begin
               ram_mem[k][a] <= cur;
               ram_vld[k][a] <= 1'b1;
            end
         end
      end
   end

   // Reference memory contents, updated only when a transaction is expected to commit.
   bit [31:0] ref_mem [2][256];
   bit        ref_vld [2][256];

   function automatic logic [31:0] ref_rd(input int k, input int w);
      return ref_vld[k][w] ? ref_mem[k][w] : fill(k, w);
   endfunction

   // Reference LFSR (x^8+x^6+x^5+x^4+1), only consulted in the random-delay build.
   logic [7:0] m_lfsr;
   always @(posedge clk) begin
      if (rst) m_lfsr <= 8'h01;
      else     m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
   end

   function automatic int exp_delay(input int k);
`ifdef RAND_DELAY_EN
      return int'(m_lfsr[3:0]) + 0 * k;
`else
      return (k == 0) ? DLY0 : DLY1;
`endif
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One request on instance k, issued right after a negedge. p = cycle (relative to the accept
   // cycle t) in which req is dropped; 0 = normal, LATE = during ACCESS.
   task automatic txn(input int k, input logic [31:0] a, input logic [31:0] d, input logic w,
                      input logic [3:0] be, input int p, input string tag, output logic [31:0] rd);
      int dd, pp, last, en_cnt, en_cyc, dok_cnt, dok_cyc, ok_err, wi;
      bit flush;
      logic [3:0]  wen_seen;
      logic [AW-1:0] ra_seen;
      logic [31:0] wd_seen, dout_seen, exp_rd, cur;
      en_cnt = 0; en_cyc = 0; dok_cnt = 0; dok_cyc = 0; ok_err = 0;
      wen_seen = 4'hF; ra_seen = '0; wd_seen = '0; dout_seen = 32'hFFFF_FFFF;
      check({tag, "_idle"}, 32'(addr_ok_s[k]), 32'd1);
      dd    = exp_delay(k);
      pp    = (p == LATE) ? dd + 1 : p;
      flush = (pp >= 1) && (pp <= dd);
      wi    = int'(a[AW+1:2]);
      exp_rd = w ? 32'd0 : ref_rd(k, wi);
      last  = flush ? pp + 1 : dd + 3;
      req_s[k] = 1'b1; addr_s[k] = a; din_s[k] = d; wr_s[k] = w; ben_s[k] = be;
      for (int cyc = 1; cyc <= last; cyc++) begin
         @(negedge clk);
         if (ram_en_s[k] === 1'b1) begin
            en_cnt++; en_cyc = cyc;
            wen_seen = ram_wen_s[k]; ra_seen = ram_addr_s[k]; wd_seen = ram_wdata_s[k];
         end
         if (data_ok_s[k] === 1'b1) begin
            dok_cnt++; dok_cyc = cyc; dout_seen = dout_s[k];
         end
         if (addr_ok_s[k] !== (cyc == last)) ok_err++;
         if (cyc == 1) begin
            addr_s[k] = $urandom; din_s[k] = $urandom; wr_s[k] = 1'($urandom); ben_s[k] = 4'($urandom);
         end
         if (cyc == pp || cyc == dd + 2) req_s[k] = 1'b0;
      end
      req_s[k] = 1'b0;
      check({tag, "_addr_ok_seq"}, 32'(ok_err), 32'd0);
      if (flush) begin
         check({tag, "_flush_en"}, 32'(en_cnt), 32'd0);
         check({tag, "_flush_dok"}, 32'(dok_cnt), 32'd0);
         rd = 32'd0;
      end else begin
         check({tag, "_en_cnt"}, 32'(en_cnt), 32'd1);
         check({tag, "_en_cyc"}, 32'(en_cyc), 32'(dd + 1));
         check({tag, "_wen"}, 32'(wen_seen), 32'(w ? be : 4'd0));
         check({tag, "_ram_addr"}, 32'(ra_seen), 32'(a[AW+1:2]));
         check({tag, "_wdata"}, wd_seen, d);
         check({tag, "_dok_cnt"}, 32'(dok_cnt), 32'd1);
         check({tag, "_dok_cyc"}, 32'(dok_cyc), 32'(dd + 2));
         check({tag, "_dout"}, dout_seen, exp_rd);
         rd = dout_seen;
         if (w) begin
            cur = ref_rd(k, wi);
            for (int b = 0; b < 4; b++)
               if (be[b]) cur[8*b +: 8] = d[8*b +: 8];
            ref_mem[k][wi] = cur;
            ref_vld[k][wi] = 1'b1;
         end
      end
   endtask

   initial begin
      logic [31:0] rd, a, d;
      int k, p, dd, gap;
      rst = 1'b1;
      for (int i = 0; i < 2; i++) begin
         req_s[i] = 1'b0; addr_s[i] = '0; din_s[i] = '0; wr_s[i] = 1'b0; ben_s[i] = 4'd0;
      end

      // Reset: all outputs low while rst is high, idle once released.
      repeat (3) @(negedge clk);
      check("rst_addr_ok0", 32'(addr_ok_s[0]), 32'd0);
      check("rst_addr_ok1", 32'(addr_ok_s[1]), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      check("post_rst_addr_ok0", 32'(addr_ok_s[0]), 32'd1);
      check("post_rst_addr_ok1", 32'(addr_ok_s[1]), 32'd1);
      check("post_rst_data_ok0", 32'(data_ok_s[0]), 32'd0);
      check("post_rst_ram_en1", 32'(ram_en_s[1]), 32'd0);

      // Zero-delay read of a preloaded word.
      txn(0, 32'h0000_0040, 32'hDEADBEEF, 1'b1, 4'hF, 0, "pre0", rd);
      txn(0, 32'h0000_0040, 32'h0, 1'b0, 4'h0, 0, "rd0", rd);
      check("rd0_value", rd, 32'hDEADBEEF);

      // Byte write on the delayed instance.
      txn(1, 32'h0000_0040, 32'h11223344, 1'b1, 4'hF, 0, "pre1", rd);
      txn(1, 32'h0000_0040, 32'hAABBCCDD, 1'b1, 4'b0100, 0, "bw1", rd);
      check("bw1_dout_zero", rd, 32'd0);
      txn(1, 32'h0000_0040, 32'h0, 1'b0, 4'h0, 0, "bw1_rd", rd);
      check("bw1_merge", rd, 32'h11BB3344);

      // Flush while waiting: no access, memory untouched.
      txn(1, 32'h0000_0044, 32'h5555_5555, 1'b1, 4'hF, 2, "flush", rd);
      txn(1, 32'h0000_0044, 32'h0, 1'b0, 4'h0, 0, "flush_rd", rd);

      // Late flush during ACCESS still commits the write.
      txn(1, 32'h0000_0048, 32'h7777_7777, 1'b1, 4'hF, LATE, "late", rd);
      txn(1, 32'h0000_0048, 32'h0, 1'b0, 4'h0, 0, "late_rd", rd);
      check("late_value", rd, 32'h7777_7777);

      // Upper address bits alias onto the same word.
      txn(0, 32'h1234_5C40, 32'hCAFEF00D, 1'b1, 4'hF, 0, "alias_wr", rd);
      txn(0, 32'h0000_0040, 32'h0, 1'b0, 4'h0, 0, "alias_rd", rd);
      check("alias_value", rd, 32'hCAFEF00D);

      // Reset raised in the ACCESS cycle of a write suppresses it.
      dd = exp_delay(1);
      req_s[1] = 1'b1; addr_s[1] = 32'h0000_0088; din_s[1] = 32'h0BAD_0BAD; wr_s[1] = 1'b1; ben_s[1] = 4'hF;
      repeat (dd + 1) @(negedge clk);
      check("rstacc_en_before", 32'(ram_en_s[1]), 32'd1);
      rst = 1'b1;
      #1;
      check("rstacc_wen", 32'(ram_wen_s[1]), 32'd0);
      check("rstacc_en", 32'(ram_en_s[1]), 32'd0);
      req_s[1] = 1'b0;
      @(negedge clk);
      check("rstacc_dok", 32'(data_ok_s[1]), 32'd0);
      rst = 1'b0;
      #1;
      check("rstacc_idle", 32'(addr_ok_s[1]), 32'd1);
      @(negedge clk);
      check("rstacc_dok2", 32'(data_ok_s[1]), 32'd0);
      txn(1, 32'h0000_0088, 32'h0, 1'b0, 4'h0, 0, "rstacc_rd", rd);
      check("rstacc_unchanged", rd, fill(1, 32'h22));

      // Random traffic on a small window of words, with idle gaps and occasional flushes.
      for (int i = 0; i < 80; i++) begin
         k = int'($urandom_range(0, 1));
         a = ($urandom & 32'hFFFF_FC00) | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
         d = $urandom;
         p = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
         txn(k, a, d, 1'($urandom), 4'($urandom), p, $sformatf("rnd%0d", i), rd);
         gap = int'($urandom_range(0, 2));
         repeat (gap) @(negedge clk);
      end

`ifdef RAND_DELAY_EN
      // Back-to-back reads: latency follows the reference LFSR.
      for (int i = 0; i < 256; i++) begin
         a = 32'($urandom_range(0, 15)) << 2;
         txn(0, a, 32'h0, 1'b0, 4'h0, 0, $sformatf("lfsr%0d", i), rd);
      end
`endif

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
